// File: rtl/tdm_demultiplexer_pkg.sv
// Shared TDM definitions: FSM state encodings, slot-width helper and default sizing,
// common to the TDM transmit and receive blocks.
package tdm_demultiplexer_pkg;

   localparam int DEF_N_CH = 4;
   localparam int DEF_W    = 8;

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // A single channel still needs a 1-bit slot register.
   function automatic int slot_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Sample-stream input and demultiplexed channel outputs of the TDM receiver.
interface tdm_demultiplexer_if #(
   parameter int N_CH = tdm_demultiplexer_pkg::DEF_N_CH,
   parameter int W    = tdm_demultiplexer_pkg::DEF_W
);
   logic [W-1:0]      din;
   logic              din_valid;
   logic              frame_sync;
   logic [N_CH*W-1:0] ch_data;
   logic [N_CH-1:0]   ch_valid;
   logic              frame_done;
   logic              sync_err;
   logic              locked;

   modport master (
      output din, din_valid, frame_sync,
      input  ch_data, ch_valid, frame_done, sync_err, locked
   );

   modport slave (
      input  din, din_valid, frame_sync,
      output ch_data, ch_valid, frame_done, sync_err, locked
   );
endinterface

// File: rtl/tdm_demultiplexer_slot_counter.sv
// Modulo-N_CH slot counter: sync clear, load-to-1 (0 when N_CH=1), increment, terminal count.
module tdm_slot_counter
   import tdm_demultiplexer_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int SW   = slot_w(N_CH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load1,
   input  logic          inc,
   output logic [SW-1:0] slot,
   output logic          tc
);

   assign tc = (slot == SW'(N_CH - 1));

   always_ff @(posedge clk) begin
      if (rst || clr)
         slot <= '0;
      else if (load1)
         slot <= (N_CH == 1) ? '0 : SW'(1);
      else if (inc)
         slot <= tc ? '0 : slot + SW'(1);
   end

endmodule

// File: rtl/tdm_demultiplexer.sv
// TDM receive end: locks onto the frame marker and steers each sample to its channel register.
module tdm_demultiplexer
   import tdm_demultiplexer_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int W    = DEF_W
) (
   input logic                clk,
   input logic                rst,
   tdm_demultiplexer_if.slave bus
);

   localparam int SW = slot_w(N_CH);

   logic [0:0]            state, state_nxt;
   logic [SW-1:0]         slot, wr_slot;
   logic                  slot_tc;
   logic                  wr_en, err, cnt_clr, cnt_load1, cnt_inc;
   logic [N_CH-1:0]       wr_vec;
   logic [N_CH-1:0][W-1:0] ch_reg;
   logic [N_CH-1:0]       ch_valid_q;
   logic                  frame_done_q, sync_err_q;

   tdm_slot_counter #(.N_CH(N_CH), .SW(SW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .slot  (slot),
      .tc    (slot_tc)
   );

   // Any marked sample is a slot-0 write, whether it starts, continues or resyncs a frame.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_slot   = '0;
      err       = 1'b0;
      cnt_clr   = 1'b0;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;
      if (bus.din_valid) begin
         if (bus.frame_sync) begin
            wr_en     = 1'b1;
            err       = (state == ST_LOCKED) && (slot != '0);
            cnt_load1 = 1'b1;
            state_nxt = ST_LOCKED;
         end else if (state == ST_LOCKED) begin
            if (slot != '0) begin
               wr_en   = 1'b1;
               wr_slot = slot;
               cnt_inc = 1'b1;
            end else begin
               err       = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_HUNT;
            end
         end
      end
   end

   always_comb begin
      wr_vec = '0;
      for (int unsigned k = 0; k < N_CH; k++)
         wr_vec[k] = wr_en && (wr_slot == SW'(k));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_HUNT;
         ch_reg       <= '0;
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state        <= state_nxt;
         ch_valid_q   <= wr_vec;
         frame_done_q <= wr_en && (wr_slot == SW'(N_CH - 1));
         sync_err_q   <= err;
         for (int unsigned k = 0; k < N_CH; k++)
            if (wr_vec[k]) ch_reg[k] <= bus.din;
      end
   end

   assign bus.ch_data    = ch_reg;
   assign bus.ch_valid   = ch_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.locked     = (state == ST_LOCKED);

endmodule
